// File: rtl/cpu_pkg.sv
// Shared opcode constants, controller state encoding and control-word layout
// for the CPU controller and the ALU.
package cpu_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned PHASE_W = 3;

   localparam logic [OP_W-1:0] OP_HLT = 3'b000;
   localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_AND = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_LDA = 3'b101;
   localparam logic [OP_W-1:0] OP_STO = 3'b110;
   localparam logic [OP_W-1:0] OP_JMP = 3'b111;

   // S0..S7 encode their own phase index in the low bits
   typedef enum logic [STATE_W-1:0] {
      ST_S0   = 4'd0,  // INST_ADDR
      ST_S1   = 4'd1,  // INST_FETCH
      ST_S2   = 4'd2,  // INST_LOAD
      ST_S3   = 4'd3,  // IDLE
      ST_S4   = 4'd4,  // OP_ADDR
      ST_S5   = 4'd5,  // OP_FETCH
      ST_S6   = 4'd6,  // ALU_OP
      ST_S7   = 4'd7,  // STORE
      ST_HALT = 4'd8
   } state_t;

   // Control strobes produced by the decoder
   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_ac;
      logic data_e;
      logic wr;
      logic halt;
   } ctrl_t;

   // Opcodes whose result is produced by the ALU and loaded into the accumulator
   function automatic logic is_aluop(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of controller state, opcode and zero flag into strobes.
module cpu_ctrl_decode
   import cpu_pkg::*;
(
   input  state_t          state_i,
   input  logic [OP_W-1:0] opcode_i,
   input  logic            zero_i,
   output ctrl_t           ctrl_o
);

   logic alu_op;
   logic skip_c;
   logic is_jmp;
   logic is_sto;

   assign alu_op = is_aluop(opcode_i);
   assign skip_c = (opcode_i == OP_SKZ) && zero_i;
   assign is_jmp = (opcode_i == OP_JMP);
   assign is_sto = (opcode_i == OP_STO);

   // Per-state strobe table; anything not set stays low
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_S0: begin
            ctrl_o.sel = 1'b1;
         end
         ST_S1: begin
            ctrl_o.sel = 1'b1;
            ctrl_o.rd  = 1'b1;
         end
         ST_S2, ST_S3: begin
            ctrl_o.sel   = 1'b1;
            ctrl_o.rd    = 1'b1;
            ctrl_o.ld_ir = 1'b1;
         end
         ST_S4: begin
            ctrl_o.inc_pc = 1'b1;
            ctrl_o.halt   = (opcode_i == OP_HLT);
         end
         ST_S5: begin
            ctrl_o.rd = alu_op;
         end
         ST_S6: begin
            ctrl_o.rd     = alu_op;
            ctrl_o.inc_pc = skip_c;
            ctrl_o.ld_pc  = is_jmp;
            ctrl_o.data_e = is_sto;
         end
         ST_S7: begin
            ctrl_o.rd     = alu_op;
            ctrl_o.ld_ac  = alu_op;
            ctrl_o.inc_pc = skip_c;
            ctrl_o.ld_pc  = is_jmp;
            ctrl_o.wr     = is_sto;
            ctrl_o.data_e = is_sto;
         end
         ST_HALT: begin
            ctrl_o.halt = 1'b1;
         end
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the simple accumulator CPU.
// Optional single-step hold in S7 is enabled by defining CPU_CTRL_STEP_EN.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int unsigned OPCODE_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
`ifdef CPU_CTRL_STEP_EN
   input  logic                step,
`endif
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                inc_pc,
   output logic                ld_pc,
   output logic                ld_ac,
   output logic                data_e,
   output logic                wr,
   output logic                halt,
   output logic [OPCODE_W-1:0] alu_op,
   output logic [PHASE_W-1:0]  phase
);

   state_t state_q;
   ctrl_t  ctrl;
   logic   one_shot_mask;

`ifdef CPU_CTRL_STEP_EN
   logic   held_q;

   // Phase sequencer; S7 waits for step, HALT is left only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_S0;
         held_q  <= 1'b0;
      end else begin
         held_q <= 1'b0;
         case (state_q)
            ST_S4:   state_q <= (3'(opcode) == OP_HLT) ? ST_HALT : ST_S5;
            ST_S7: begin
               if (step) begin
                  state_q <= ST_S0;
               end else begin
                  held_q  <= 1'b1;
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= state_t'(state_q + 4'd1);
         endcase
      end
   end

   // Strobes that change machine state fire only in the first S7 cycle
   assign one_shot_mask = held_q;
`else
   // Phase sequencer; HALT is left only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_S0;
      end else begin
         case (state_q)
            ST_S4:   state_q <= (3'(opcode) == OP_HLT) ? ST_HALT : ST_S5;
            ST_S7:   state_q <= ST_S0;
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= state_t'(state_q + 4'd1);
         endcase
      end
   end

   assign one_shot_mask = 1'b0;
`endif

   cpu_ctrl_decode u_decode (
      .state_i  (state_q),
      .opcode_i (3'(opcode)),
      .zero_i   (zero),
      .ctrl_o   (ctrl)
   );

   assign sel    = ctrl.sel;
   assign rd     = ctrl.rd;
   assign ld_ir  = ctrl.ld_ir;
   assign data_e = ctrl.data_e;
   assign halt   = ctrl.halt;
   assign inc_pc = ctrl.inc_pc & ~one_shot_mask;
   assign ld_pc  = ctrl.ld_pc  & ~one_shot_mask;
   assign ld_ac  = ctrl.ld_ac  & ~one_shot_mask;
   assign wr     = ctrl.wr     & ~one_shot_mask;
   assign alu_op = opcode;
   assign phase  = (state_q == ST_HALT) ? '0 : PHASE_W'(state_q);

endmodule
